bullet_pool: RTL and testbench

Multi-bullet successor to the single-shot bullet block: a parametrised pool of up to NBULL independent vertical projectiles sharing one renderer. Sits beside the player/ball logic on the 25 MHz pixel pipeline, draws all live bullets, and scans the frame for collisions ahead of each bullet. Adds rate limiting, multi-pixel speed with tunnel-proof collision look-ahead, and a per-hit report to the scoring logic.

---
 rtl/bullet_pool.sv | 112 +++++++++++
 tb/tb_bullet_pool.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: pool of NBULL upward projectiles with shared draw, swept-band collision scan and rate-limited launch
module bullet_pool #(
    parameter int NBULL    = 4,
    parameter int XSIZE    = 3,
    parameter int YSIZE    = 5,
    parameter int SPEED    = 2,
    parameter int COOLDOWN = 8,
    parameter int YMIN     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixpulse,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  empty,
    input  logic                  move,
    input  logic                  shoot,
    input  logic [9:0]            xloc_start,
    input  logic [9:0]            yloc_start,
    output logic                  draw_bullet,
    output logic [NBULL-1:0]      active,
    output logic [10*NBULL-1:0]   xloc_all,
    output logic [10*NBULL-1:0]   yloc_all,
    output logic                  hit,
    output logic [2:0]            hit_slot,
    output logic [9:0]            hit_x
);
    localparam int CW = $clog2(COOLDOWN + 2);
    localparam logic [10:0] HX = 11'((XSIZE - 1) / 2);
    localparam logic [10:0] HY = 11'((YSIZE - 1) / 2);
    localparam logic [10:0] SP = 11'(SPEED);
    localparam logic [10:0] YTOP = 11'(YMIN + (YSIZE - 1) / 2 + SPEED);
    logic [9:0] xloc [NBULL];
    logic [9:0] yloc [NBULL];
    logic [NBULL-1:0] blocked, xin, ycov, sweep, take;
    logic [CW-1:0] cooldown;
    logic shoot_q, armed, launch, any_hit;
    logic [2:0] hit_slot_n;
    logic [9:0] hit_x_n;
    wire [10:0] hc = {1'b0, hcount};
    wire [10:0] vc = {1'b0, vcount};
    for (genvar g = 0; g < NBULL; g++) begin : g_slot
        wire [10:0] x = {1'b0, xloc[g]};
        wire [10:0] y = {1'b0, yloc[g]};
        assign xin[g]   = hc + HX >= x && hc <= x + HX;
        assign ycov[g]  = vc + HY >= y && vc <= y + HY;
        // bullet's next SPEED rows above its top edge: checking the whole band stops fast bullets tunnelling
        assign sweep[g] = y >= vc + HY + 11'd1 && y <= vc + HY + SP;
        assign xloc_all[10*g +: 10] = xloc[g];
        assign yloc_all[10*g +: 10] = yloc[g];
    end
    assign draw_bullet = |(active & xin & ycov);
    assign any_hit = |(active & blocked);
    always_comb begin
        take = '0;
        hit_slot_n = '0;
        hit_x_n = '0;
        for (int i = NBULL - 1; i >= 0; i--) begin
            if (!active[i]) begin
                take = '0;
                take[i] = 1'b1;
            end
            if (active[i] && blocked[i]) begin
                hit_slot_n = 3'(i);
                hit_x_n = xloc[i];
            end
        end
    end
    // armed keeps a shoot level held across reset from counting as a fresh edge
    assign launch = shoot && !shoot_q && armed && cooldown == '0 && |take;
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            blocked <= '0;
            cooldown <= '0;
            shoot_q <= 1'b0;
            armed <= 1'b0;
            hit <= 1'b0;
            hit_slot <= '0;
            hit_x <= '0;
            for (int i = 0; i < NBULL; i++) begin
                xloc[i] <= '0;
                yloc[i] <= '0;
            end
        end else if (pixpulse) begin
            shoot_q <= shoot;
            if (!shoot) armed <= 1'b1;
            hit <= move && any_hit;
            if (move && any_hit) begin
                hit_slot <= hit_slot_n;
                hit_x <= hit_x_n;
            end
            for (int i = 0; i < NBULL; i++) begin
                if (move) begin
                    blocked[i] <= 1'b0;
                    if (active[i] && (blocked[i] || {1'b0, yloc[i]} < YTOP)) active[i] <= 1'b0;
                    else if (active[i]) yloc[i] <= yloc[i] - 10'(SPEED);
                end else if (!empty && active[i] && xin[i] && sweep[i]) begin
                    blocked[i] <= 1'b1;
                end
                if (launch && take[i]) begin
                    active[i] <= 1'b1;
                    blocked[i] <= 1'b0;
                    xloc[i] <= xloc_start;
                    yloc[i] <= yloc_start;
                end
            end
            if (launch) cooldown <= CW'(COOLDOWN);
            else if (move && cooldown != '0) cooldown <= cooldown - 1'b1;
        end
    end
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed scenarios plus randomized traffic, checked against a slot-list reference model
module tb_bullet_pool;
    localparam int NB = 4, XS = 3, YS = 5, SPD = 2, COOL = 8, YMN = 8;
    localparam int HX = (XS - 1) / 2, HY = (YS - 1) / 2;
    logic clk = 0, rst = 0, pixpulse = 0, empty = 1, move = 0, shoot = 0;
    logic [9:0] hcount = 0, vcount = 0, xloc_start = 0, yloc_start = 0;
    logic draw_bullet, hit;
    logic [NB-1:0] active;
    logic [10*NB-1:0] xloc_all, yloc_all;
    logic [2:0] hit_slot;
    logic [9:0] hit_x;
    int total = 0, bad = 0;
    bit ma[NB], mb[NB];
    int mx[NB], my[NB];
    int mcool, mhs, mhx;
    bit msq, marm, mhit;
    bullet_pool #(.NBULL(NB), .XSIZE(XS), .YSIZE(YS), .SPEED(SPD), .COOLDOWN(COOL), .YMIN(YMN)) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .shoot(shoot), .xloc_start(xloc_start), .yloc_start(yloc_start),
        .draw_bullet(draw_bullet), .active(active), .xloc_all(xloc_all), .yloc_all(yloc_all),
        .hit(hit), .hit_slot(hit_slot), .hit_x(hit_x)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic void mreset();
        for (int i = 0; i < NB; i++) begin
            ma[i] = 0; mb[i] = 0; mx[i] = 0; my[i] = 0;
        end
        mcool = 0; msq = 0; marm = 0; mhit = 0; mhs = 0; mhx = 0;
    endfunction
    function automatic bit mdraw(int h, int v);
        bit d = 0;
        for (int i = 0; i < NB; i++)
            if (ma[i] && h >= mx[i] - HX && h <= mx[i] + HX && v >= my[i] - HY && v <= my[i] + HY) d = 1;
        return d;
    endfunction
    function automatic void mstep(bit mv, bit sh, bit em, int h, int v);
        int fr = -1, hs = -1;
        for (int i = 0; i < NB; i++) if (fr < 0 && !ma[i]) fr = i;
        for (int i = 0; i < NB; i++) begin
            if (mv) begin
                if (ma[i]) begin
                    if (mb[i]) begin
                        ma[i] = 0;
                        if (hs < 0) hs = i;
                    end else if (my[i] - HY - SPD < YMN) ma[i] = 0;
                    else my[i] -= SPD;
                end
                mb[i] = 0;
            end else if (!em && ma[i] && h >= mx[i] - HX && h <= mx[i] + HX
                         && v >= my[i] - HY - SPD && v <= my[i] - HY - 1) mb[i] = 1;
        end
        mhit = mv && hs >= 0;
        if (hs >= 0) begin
            mhs = hs; mhx = mx[hs];
        end
        if (sh && !msq && marm && mcool == 0 && fr >= 0) begin
            ma[fr] = 1; mb[fr] = 0; mx[fr] = int'(xloc_start); my[fr] = int'(yloc_start);
            mcool = COOL;
        end else if (mv && mcool > 0) mcool--;
        msq = sh;
        if (!sh) marm = 1;
    endfunction
    task automatic cmp_state();
        logic [NB-1:0] ea;
        logic [10*NB-1:0] ex, ey;
        for (int i = 0; i < NB; i++) begin
            ea[i] = ma[i]; ex[10*i +: 10] = 10'(mx[i]); ey[10*i +: 10] = 10'(my[i]);
        end
        check("active", 64'(active), 64'(ea));
        check("xloc_all", 64'(xloc_all), 64'(ex));
        check("yloc_all", 64'(yloc_all), 64'(ey));
        check("hit", 64'(hit), 64'(mhit));
        check("hit_slot", 64'(hit_slot), 64'(mhs));
        check("hit_x", 64'(hit_x), 64'(mhx));
    endtask
    task automatic step(input bit pp, input bit mv, input bit sh, input bit em, input int h, input int v);
        @(negedge clk);
        pixpulse = pp; move = mv; shoot = sh; empty = em;
        hcount = 10'(h & 1023); vcount = 10'(v & 1023);
        #1 check("draw", 64'(draw_bullet), 64'(mdraw(h & 1023, v & 1023)));
        @(posedge clk);
        #1 if (pp) mstep(mv, sh, em, h & 1023, v & 1023);
        cmp_state();
    endtask
    task automatic pix(input bit mv, input bit sh, input bit em, input int h, input int v);
        step(1, mv, sh, em, h, v);
        repeat (3) step(0, 0, sh, em, h, v);
    endtask
    task automatic do_reset(input bit sh);
        @(negedge clk);
        rst = 1; shoot = sh; pixpulse = 0; move = 0;
        repeat (2) @(posedge clk);
        #1 mreset();
        cmp_state();
        @(negedge clk) rst = 0;
    endtask
    task automatic probe(input string tag, input int h, input int v, input bit exp);
        @(negedge clk);
        pixpulse = 0; hcount = 10'(h); vcount = 10'(v);
        #1 check(tag, 64'(draw_bullet), 64'(exp));
    endtask
    task automatic arm_launch(input int x, input int y);
        xloc_start = 10'(x); yloc_start = 10'(y);
        pix(0, 0, 1, 0, 0);
        pix(0, 1, 1, 0, 0);
    endtask
    initial begin
        mreset();
        do_reset(0);
        check("rst_active", 64'(active), 64'h0);
        check("rst_draw", 64'(draw_bullet), 64'h0);
        arm_launch(320, 400);
        check("launch_active", 64'(active), 64'h1);
        check("launch_x", 64'(xloc_all[9:0]), 64'd320);
        check("launch_y", 64'(yloc_all[9:0]), 64'd400);
        probe("draw_ul", 319, 398, 1);
        probe("draw_lr", 321, 402, 1);
        probe("draw_right_out", 322, 400, 0);
        probe("draw_below_out", 320, 403, 0);
        pix(0, 0, 1, 0, 0);
        repeat (10) pix(1, 0, 1, 0, 0);
        check("flight_y", 64'(yloc_all[9:0]), 64'd380);
        check("flight_active", 64'(active), 64'h1);
        do_reset(0);
        arm_launch(320, 100);
        pix(0, 0, 0, 321, 96);
        step(1, 1, 0, 1, 0, 0);
        check("coll_hit", 64'(hit), 64'h1);
        check("coll_active", 64'(active), 64'h0);
        check("coll_slot", 64'(hit_slot), 64'h0);
        check("coll_x", 64'(hit_x), 64'd320);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        check("coll_hold", 64'(hit), 64'h1);
        pix(0, 0, 1, 0, 0);
        check("coll_pulse_end", 64'(hit), 64'h0);
        check("coll_x_held", 64'(hit_x), 64'd320);
        do_reset(0);
        arm_launch(320, 100);
        pix(0, 0, 0, 321, 94);
        pix(1, 0, 1, 0, 0);
        check("miss_active", 64'(active), 64'h1);
        check("miss_y", 64'(yloc_all[9:0]), 64'd98);
        do_reset(0);
        arm_launch(100, 12);
        pix(1, 0, 1, 0, 0);
        check("top_step_y", 64'(yloc_all[9:0]), 64'd10);
        pix(1, 0, 1, 0, 0);
        check("top_exit_active", 64'(active), 64'h0);
        check("top_exit_hit", 64'(hit), 64'h0);
        do_reset(0);
        arm_launch(50, 470);
        pix(1, 0, 1, 0, 0);
        pix(1, 1, 1, 0, 0);
        check("cooldown_drop", 64'(active), 64'h1);
        do_reset(0);
        xloc_start = 10'd200; yloc_start = 10'd470;
        pix(0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            pix(0, 1, 1, 0, 0);
            pix(0, 0, 1, 0, 0);
            repeat (8) pix(1, 0, 1, 0, 0);
        end
        check("pool_full", 64'(active), 64'hf);
        do_reset(1);
        pix(0, 1, 1, 0, 0);
        check("rst_held_no_launch", 64'(active), 64'h0);
        pix(0, 0, 1, 0, 0);
        pix(0, 1, 1, 0, 0);
        check("rst_relaunch", 64'(active), 64'h1);
        for (int n = 0; n < 3000; n++) begin
            int t, h, v;
            bit sh;
            t = $urandom_range(0, NB - 1);
            h = mx[t] + int'($urandom_range(0, 4)) - 2;
            v = my[t] - int'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 639); v = $urandom_range(0, 479);
            end
            sh = ($urandom_range(0, 2) == 0) ? !shoot : shoot;
            xloc_start = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 3)) : 10'($urandom_range(0, 639));
            yloc_start = 10'($urandom_range(9, 470));
            if ($urandom_range(0, 499) == 0) do_reset(sh);
            pix($urandom_range(0, 3) == 0, sh, $urandom_range(0, 4) != 0, h, v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
